// File: rtl/irq_coalesce_ctrl.sv
// irq_coalesce_ctrl
//   Per-channel interrupt coalescing with holdoff. It watches the TRN receive
//   stream for BAR2 memory writes that arm, disable, or set the holdoff reload.
//   It picks an eligible channel round-robin. It then runs the TX arbitration
//   and cfg_interrupt handshake with the core.
//
// Ports
//   trn_clk, reset          clock, synchronous active-high reset
//   trn_r*                  TRN receive stream (monitor only, never back-pressured)
//   trn_tbuf_av             TX buffer availability, bit 1 gates interrupt issue
//   cfg_interrupt_n/_di     interrupt request and MSI vector to the core
//   cfg_interrupt_rdy_n     core acknowledge
//   my_turn, req_ep,
//   driving_interface       TX arbitration handshake
//   send_interrupt          per-channel event pulses
//
// Issue FSM
//   state      | meaning
//   S_IDLE     | waiting for an eligible channel with holdoff expired
//   S_REQ      | req_ep raised, waiting for my_turn
//   S_CHECK    | owning the interface, checking TX buffer space
//   S_ASSERT   | cfg_interrupt_n low, waiting for core acknowledge
//   S_WAIT_BUF | interface released, waiting for TX buffer space
//
// Decode FSM
//   state      | meaning
//   D_IDLE     | looking for a BAR2 MWr32/MWr64 start of frame
//   D_ADDR32   | next beat carries the 32-bit address and data dword
//   D_ADDR64   | next beat carries the 64-bit address (low dword at [31:0])

module irq_coalesce_ctrl #(
  parameter int          NUM_CH       = 4,
  parameter int          TIMER_W      = 16,
  parameter int unsigned HOLDOFF_INIT = 0,
  parameter logic [5:0]  REG_BASE     = 6'h08
) (
  input  logic              trn_clk,
  input  logic              reset,
  input  logic [63:0]       trn_rd,
  input  logic [7:0]        trn_rrem_n,
  input  logic              trn_rsof_n,
  input  logic              trn_reof_n,
  input  logic              trn_rsrc_rdy_n,
  input  logic              trn_rsrc_dsc_n,
  input  logic [6:0]        trn_rbar_hit_n,
  input  logic              trn_rdst_rdy_n,
  input  logic [3:0]        trn_tbuf_av,
  output logic              cfg_interrupt_n,
  output logic [7:0]        cfg_interrupt_di,
  input  logic              cfg_interrupt_rdy_n,
  input  logic              my_turn,
  output logic              req_ep,
  output logic              driving_interface,
  input  logic [NUM_CH-1:0] send_interrupt
);

  localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [6:0] FT_MWR32 = 7'h40;
  localparam logic [6:0] FT_MWR64 = 7'h60;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_CHECK, S_ASSERT, S_WAIT_BUF} issue_state_t;
  typedef enum logic [1:0] {D_IDLE, D_ADDR32, D_ADDR64} dec_state_t;

  issue_state_t        state, state_nxt;
  dec_state_t          dec_state, dec_nxt;

  logic [NUM_CH-1:0]   pending, armed, disabled;
  logic [NUM_CH-1:0]   eligible, clr_mask, arm_set, dis_set;
  logic [CH_W-1:0]     ch_sel, ch_sel_nxt, rr_ptr, rr_nxt, pick, rr_idx;
  logic                pick_vld;
  logic [TIMER_W-1:0]  holdoff_cnt, holdoff_reload;

  logic                req_ep_nxt, drv_nxt, int_n_nxt, ack_fire;
  logic [7:0]          di_nxt;

  logic                beat_ok, sof_hit, reg_wr, wr_is32, reload_wr;
  logic [5:0]          wr_off;

  // Inputs the block only partly consumes; folding them here keeps lint quiet.
  logic                unused_ok;
  assign unused_ok = ^{trn_rd, trn_rrem_n, trn_reof_n, trn_rbar_hit_n,
                       trn_tbuf_av[3:2], trn_tbuf_av[0]};

  // ---------------------------------------------------------------- decode
  assign beat_ok = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
  assign sof_hit = beat_ok && !trn_rsof_n && trn_rsrc_dsc_n && !trn_rbar_hit_n[2];

  always_comb begin
    dec_nxt = dec_state;
    reg_wr  = 1'b0;
    wr_is32 = 1'b0;
    wr_off  = '0;
    case (dec_state)
      D_IDLE: begin
        if (sof_hit && trn_rd[62:56] == FT_MWR32)      dec_nxt = D_ADDR32;
        else if (sof_hit && trn_rd[62:56] == FT_MWR64) dec_nxt = D_ADDR64;
      end
      D_ADDR32: begin
        if (!trn_rsrc_dsc_n) dec_nxt = D_IDLE;
        else if (beat_ok) begin
          reg_wr  = 1'b1;
          wr_is32 = 1'b1;
          wr_off  = trn_rd[39:34];
          dec_nxt = D_IDLE;
        end
      end
      D_ADDR64: begin
        if (!trn_rsrc_dsc_n) dec_nxt = D_IDLE;
        else if (beat_ok) begin
          reg_wr  = 1'b1;
          wr_off  = trn_rd[7:2];
          dec_nxt = D_IDLE;
        end
      end
      default: dec_nxt = D_IDLE;
    endcase
  end

  // Each channel owns two consecutive dwords: arm at even, disable at odd.
  always_comb begin
    arm_set   = '0;
    dis_set   = '0;
    reload_wr = 1'b0;
    if (reg_wr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_off == 6'(REG_BASE + 2 * c))     arm_set[c] = 1'b1;
        if (wr_off == 6'(REG_BASE + 2 * c + 1)) dis_set[c] = 1'b1;
      end
      if (wr_is32 && wr_off == 6'(REG_BASE + 2 * NUM_CH)) reload_wr = 1'b1;
    end
  end

  // ---------------------------------------------------------------- arbitration
  assign eligible = pending & armed & ~disabled;

  // Search starts one past the last serviced channel and wraps.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      rr_idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!pick_vld && eligible[rr_idx]) begin
        pick_vld = 1'b1;
        pick     = rr_idx;
      end
    end
  end

  // ---------------------------------------------------------------- issue FSM
  always_comb begin
    state_nxt  = state;
    req_ep_nxt = req_ep;
    drv_nxt    = driving_interface;
    int_n_nxt  = cfg_interrupt_n;
    di_nxt     = cfg_interrupt_di;
    ch_sel_nxt = ch_sel;
    rr_nxt     = rr_ptr;
    ack_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_vld && holdoff_cnt == '0) begin
          ch_sel_nxt = pick;
          rr_nxt     = pick;
          req_ep_nxt = 1'b1;
          state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        if (my_turn) begin
          req_ep_nxt = 1'b0;
          drv_nxt    = 1'b1;
          state_nxt  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (trn_tbuf_av[1]) begin
          int_n_nxt = 1'b0;
          di_nxt    = 8'(ch_sel);
          state_nxt = S_ASSERT;
        end else begin
          drv_nxt   = 1'b0;
          state_nxt = S_WAIT_BUF;
        end
      end
      S_WAIT_BUF: begin
        if (trn_tbuf_av[1]) begin
          req_ep_nxt = 1'b1;
          state_nxt  = S_REQ;
        end
      end
      // The latched channel is serviced even if it was disabled meanwhile.
      S_ASSERT: begin
        if (!cfg_interrupt_rdy_n) begin
          int_n_nxt = 1'b1;
          drv_nxt   = 1'b0;
          ack_fire  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    if (ack_fire) clr_mask[ch_sel] = 1'b1;
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state             <= S_IDLE;
      dec_state         <= D_IDLE;
      pending           <= '0;
      armed             <= '1;
      disabled          <= '0;
      ch_sel            <= '0;
      rr_ptr            <= CH_W'(NUM_CH - 1);
      req_ep            <= 1'b0;
      driving_interface <= 1'b0;
      cfg_interrupt_n   <= 1'b1;
      cfg_interrupt_di  <= 8'h00;
      holdoff_cnt       <= '0;
      holdoff_reload    <= TIMER_W'(HOLDOFF_INIT);
    end else begin
      state             <= state_nxt;
      dec_state         <= dec_nxt;
      // A new event in the acknowledge cycle survives the clear.
      pending           <= (pending & ~clr_mask) | send_interrupt;
      armed             <= (armed & ~clr_mask) | arm_set;
      disabled          <= (disabled | dis_set) & ~arm_set;
      ch_sel            <= ch_sel_nxt;
      rr_ptr            <= rr_nxt;
      req_ep            <= req_ep_nxt;
      driving_interface <= drv_nxt;
      cfg_interrupt_n   <= int_n_nxt;
      cfg_interrupt_di  <= di_nxt;
      if (reload_wr) holdoff_reload <= trn_rd[TIMER_W-1:0];
      if (ack_fire)                holdoff_cnt <= holdoff_reload;
      else if (holdoff_cnt != '0)  holdoff_cnt <= holdoff_cnt - TIMER_W'(1);
    end
  end

endmodule

// File: tb/tb_irq_coalesce_ctrl.sv
module tb_irq_coalesce_ctrl;

  logic        trn_clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] trn_rd = '0;
  logic [7:0]  trn_rrem_n = '0;
  logic        trn_rsof_n = 1'b1;
  logic        trn_reof_n = 1'b1;
  logic        trn_rsrc_rdy_n = 1'b1;
  logic        trn_rsrc_dsc_n = 1'b1;
  logic [6:0]  trn_rbar_hit_n = 7'h7f;
  logic        trn_rdst_rdy_n = 1'b0;
  logic [3:0]  trn_tbuf_av = 4'b0000;
  logic        cfg_interrupt_n;
  logic [7:0]  cfg_interrupt_di;
  logic        cfg_interrupt_rdy_n = 1'b1;
  logic        my_turn = 1'b0;
  logic        req_ep;
  logic        driving_interface;
  logic [3:0]  send_interrupt = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  irq_coalesce_ctrl dut (
    .trn_clk(trn_clk), .reset(reset),
    .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n),
    .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rbar_hit_n(trn_rbar_hit_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
    .cfg_interrupt_n(cfg_interrupt_n), .cfg_interrupt_di(cfg_interrupt_di),
    .cfg_interrupt_rdy_n(cfg_interrupt_rdy_n), .my_turn(my_turn),
    .req_ep(req_ep), .driving_interface(driving_interface),
    .send_interrupt(send_interrupt)
  );

  always #5 trn_clk = ~trn_clk;
  always @(posedge trn_clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       rst;
    logic [3:0] send;
    logic       turn;
    logic       buf1;
    logic       rdy_n;
    logic       e_int_n;
    logic [7:0] e_di;
    logic       e_req;
    logic       e_drv;
  } vec_t;

  vec_t vecs[27];

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pulse(input logic [3:0] ch);
    send_interrupt = ch;
    tick();
    send_interrupt = '0;
  endtask

  // BAR2 memory write: header beat, then address beat (MWr64 adds a data beat).
  task automatic tlp_write(input bit is64, input logic [5:0] off, input logic [31:0] data,
                           input bit abort);
    trn_rd = '0;
    trn_rd[62:56] = is64 ? 7'h60 : 7'h40;
    trn_rsof_n = 1'b0;
    trn_rsrc_rdy_n = 1'b0;
    trn_rbar_hit_n = 7'b1111011;
    tick();
    trn_rsof_n = 1'b1;
    trn_rd = '0;
    if (!is64) begin
      trn_rd[39:34] = off;
      trn_rd[31:0]  = data;
      trn_reof_n    = 1'b0;
    end else begin
      trn_rd[7:2] = off;
    end
    trn_rsrc_dsc_n = abort ? 1'b0 : 1'b1;
    tick();
    trn_rsrc_dsc_n = 1'b1;
    if (is64) begin
      trn_rd = '0;
      trn_rd[63:32] = data;
      trn_reof_n = 1'b0;
      tick();
    end
    trn_rd = '0;
    trn_reof_n = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rbar_hit_n = 7'h7f;
  endtask

  task automatic service(input logic [7:0] exp_di, input logic [3:0] ack_pulse,
                         output int t_assert, output int t_ack);
    int n;
    n = 0;
    while (!req_ep && n < 400) begin tick(); n++; end
    check("req_ep_rise", req_ep, 1);
    if (!req_ep) begin
      t_assert = cyc;
      t_ack = cyc;
      return;
    end
    my_turn = 1'b1;
    tick();
    my_turn = 1'b0;
    n = 0;
    while (cfg_interrupt_n && n < 20) begin tick(); n++; end
    check("int_assert", cfg_interrupt_n, 0);
    t_assert = cyc;
    check("int_di", cfg_interrupt_di, exp_di);
    cfg_interrupt_rdy_n = 1'b0;
    send_interrupt = ack_pulse;
    tick();
    cfg_interrupt_rdy_n = 1'b1;
    send_interrupt = '0;
    t_ack = cyc;
    check("int_release", cfg_interrupt_n, 1);
  endtask

  initial begin
    int ta, tk, ta2, tk2;

    //              rst send  turn buf rdy_n | int_n di    req drv
    vecs[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1,  1'b1, 8'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'h4, 1'b0, 1'b0, 1'b1,  1'b1, 8'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1,  1'b1, 8'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1,  1'b1, 8'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1,  1'b0, 8'd2, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1,  1'b0, 8'd2, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1,  1'b0, 8'd2, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0,  1'b1, 8'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'h4, 1'b0, 1'b1, 1'b1,  1'b1, 8'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1,  1'b1, 8'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1,  1'b1, 8'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'h1, 1'b0, 1'b0, 1'b1,  1'b1, 8'd2, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1,  1'b1, 8'd2, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1,  1'b1, 8'd2, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1,  1'b1, 8'd2, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1,  1'b1, 8'd2, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1,  1'b1, 8'd2, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1,  1'b1, 8'd2, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1,  1'b0, 8'd0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0,  1'b1, 8'd0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 4'h8, 1'b0, 1'b1, 1'b1,  1'b1, 8'd0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1,  1'b1, 8'd0, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1,  1'b1, 8'd0, 1'b0, 1'b1};
    vecs[23] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1,  1'b0, 8'd3, 1'b0, 1'b1};
    vecs[24] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1,  1'b1, 8'd0, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1,  1'b1, 8'd0, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1,  1'b1, 8'd0, 1'b0, 1'b0};

    // Cycle-by-cycle vectors: single interrupt, unarmed coalescing, buffer stall, reset mid-assert.
    for (int i = 0; i < 27; i++) begin
      reset               = vecs[i].rst;
      send_interrupt      = vecs[i].send;
      my_turn             = vecs[i].turn;
      trn_tbuf_av         = {2'b00, vecs[i].buf1, 1'b0};
      cfg_interrupt_rdy_n = vecs[i].rdy_n;
      tick();
      check($sformatf("vec%0d_int_n", i), cfg_interrupt_n, vecs[i].e_int_n);
      check($sformatf("vec%0d_di", i), cfg_interrupt_di, vecs[i].e_di);
      check($sformatf("vec%0d_req_ep", i), req_ep, vecs[i].e_req);
      check($sformatf("vec%0d_drv", i), driving_interface, vecs[i].e_drv);
    end
    send_interrupt = '0;
    my_turn = 1'b0;
    cfg_interrupt_rdy_n = 1'b1;
    trn_tbuf_av = 4'b0010;

    // MWr64 disable of ch0 blocks the request; MWr32 re-arm releases it.
    tlp_write(1'b1, 6'd9, 32'h0, 1'b0);
    pulse(4'b0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("disabled_no_req", req_ep, 0);
    end
    tlp_write(1'b1, 6'd16, 32'd200, 1'b0);
    tlp_write(1'b0, 6'd8, 32'h0, 1'b0);
    service(8'd0, 4'b0000, ta, tk);

    // Discarded disable of ch1 must not take effect; MWr64 holdoff write was ignored.
    tlp_write(1'b0, 6'd11, 32'h0, 1'b1);
    pulse(4'b0010);
    service(8'd1, 4'b0000, ta2, tk2);
    check("holdoff_mwr64_ignored", (ta2 - tk) <= 20, 1);

    // Round robin: last serviced ch1, ch1 and ch3 both ready -> ch3 then ch1.
    tlp_write(1'b0, 6'd10, 32'h0, 1'b0);
    pulse(4'b1010);
    service(8'd3, 4'b0000, ta, tk);
    service(8'd1, 4'b0000, ta, tk);

    // Event during acknowledge keeps ch2 pending; re-arm re-issues it with no new event.
    pulse(4'b0100);
    service(8'd2, 4'b0100, ta, tk);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("unarmed_no_req", req_ep, 0);
    end
    tlp_write(1'b0, 6'd12, 32'h0, 1'b0);
    service(8'd2, 4'b0000, ta, tk);

    // Holdoff reload 100: second assertion no earlier than 100 cycles after first ack.
    tlp_write(1'b0, 6'd16, 32'd100, 1'b0);
    tlp_write(1'b0, 6'd8, 32'h0, 1'b0);
    tlp_write(1'b0, 6'd14, 32'h0, 1'b0);
    pulse(4'b1001);
    service(8'd3, 4'b0000, ta, tk);
    service(8'd0, 4'b0000, ta2, tk2);
    check("holdoff_min_gap", (ta2 - tk) >= 100, 1);
    check("holdoff_max_gap", (ta2 - tk) <= 106, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_coalesce_ctrl.md
IRQ_COALESCE_CTRL -- requirements
Module: irq_coalesce_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of interrupt channels (1..8).
REQ-002 Parameter TIMER_W, default 16, holdoff counter width (8..32).
REQ-003 Parameter HOLDOFF_INIT, default 0, holdoff reload value after reset.
REQ-004 Parameter REG_BASE, default 6'h08, dword offset of first control register in BAR2.
REQ-005 trn_clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rbar_hit_n, trn_rdst_rdy_n  in  64/8/1/1/1/1/7/1  TRN receive stream, monitor only.
REQ-008 trn_tbuf_av  in  4  TX buffer availability; bit 1 qualifies interrupt issue.
REQ-009 cfg_interrupt_n  out  1  active-low interrupt request to core.
REQ-010 cfg_interrupt_di  out  8  MSI vector = serviced channel index, zero-extended.
REQ-011 cfg_interrupt_rdy_n  in  1  active-low core acknowledge.
REQ-012 my_turn  in  1; req_ep  out  1; driving_interface  out  1  TX arbitration handshake.
REQ-013 send_interrupt  in  NUM_CH  per-channel event pulses, one bit per channel.

Function
REQ-014 Per channel SHALL hold pending, armed, disabled bits; reset: pending=0, armed=1, disabled=0.
REQ-015 send_interrupt[c]=1 SHALL set pending[c] the next cycle; repeated events while pending SHALL coalesce.
REQ-016 Channel c eligible iff pending & armed & !disabled.
REQ-017 Register decode: a TLP SHALL be recognised when sof, src_rdy, dst_rdy asserted, trn_rbar_hit_n[2]=0, trn_rd[62:56]=MWr32 or MWr64; non-matching TLPs ignored.
REQ-018 Dword offset A SHALL be trn_rd[39:34] (MWr32) or trn_rd[7:2] (MWr64) on next beat with src_rdy & dst_rdy; decode FSM returns to idle after that beat.
REQ-019 A=REG_BASE+2c: set armed[c], clear disabled[c], clear nothing else.
REQ-020 A=REG_BASE+2c+1: set disabled[c]; pending[c] retained.
REQ-021 A=REG_BASE+2*NUM_CH with MWr32 only: holdoff reload <= trn_rd[TIMER_W-1:0]; MWr64 to this offset ignored.
REQ-022 trn_rsrc_dsc_n=0 during decode SHALL abort decode without register effect.
REQ-023 Holdoff counter SHALL load reload value on each issued interrupt, decrement to 0, saturate; no issue while nonzero.
REQ-024 Issue FSM states: IDLE, REQ, CHECK, ASSERT, WAIT_BUF.
REQ-025 IDLE: any eligible channel & holdoff=0 -> latch channel by round-robin starting after last serviced index, req_ep=1, -> REQ.
REQ-026 REQ: my_turn=1 -> req_ep=0, driving_interface=1, -> CHECK.
REQ-027 CHECK: trn_tbuf_av[1]=1 -> cfg_interrupt_n=0, cfg_interrupt_di=channel, -> ASSERT; else driving_interface=0, -> WAIT_BUF.
REQ-028 WAIT_BUF: trn_tbuf_av[1]=1 -> req_ep=1, -> REQ.
REQ-029 ASSERT: cfg_interrupt_rdy_n=0 -> cfg_interrupt_n=1, driving_interface=0, clear pending and armed of channel, load holdoff, -> IDLE.
REQ-030 cfg_interrupt_di SHALL stay stable while cfg_interrupt_n=0.
REQ-031 Event on serviced channel same cycle as ack SHALL leave pending=1 (set wins over clear).
REQ-032 Disable of latched channel after IDLE SHALL not abort the in-flight interrupt.
REQ-033 At most one interrupt outstanding; latency event->req_ep minimum 2 cycles.

Reset
REQ-034 Reset SHALL force cfg_interrupt_n=1, cfg_interrupt_di=0, req_ep=0, driving_interface=0, FSMs idle, holdoff counter=0, reload=HOLDOFF_INIT, round-robin pointer=NUM_CH-1.
REQ-035 Reset mid-handshake SHALL drop all outputs to reset values next cycle, no residual request.

Verification
REQ-036 Pulse send_interrupt[2], my_turn granted, tbuf_av[1]=1, rdy_n low 3 cycles later -> one interrupt, di=2, channel 2 unarmed.
REQ-037 Pulses on ch1, ch3 same cycle after ch1 serviced last -> ch3 first, then ch1 after re-arm write.
REQ-038 Holdoff reload 100 via MWr32, two channels pending -> second cfg_interrupt_n low no earlier than 100 cycles after first ack.
REQ-039 tbuf_av[1]=0 at CHECK -> driving_interface drops, WAIT_BUF; tbuf_av[1]=1 -> req_ep reasserted.
REQ-040 MWr64 disable of ch0 then event -> no request; MWr32 re-enable -> interrupt with di=0.
